// File: rtl/cnn_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg
// Shared constants and helpers for the convolution front-end blocks.
//   KERNEL_SZ  : kernel edge length (3x3 windows)
//   PIX_W_DEF  : default activation width in bits
//   ROW_W      : width of one packed window row at the default pixel width
//   win_count(): number of stride-1 windows in an h x w image
// ---------------------------------------------------------------------------
package cnn_pkg;

   localparam int KERNEL_SZ = 3;
   localparam int PIX_W_DEF = 8;
   localparam int ROW_W     = KERNEL_SZ * PIX_W_DEF;

   // Windows produced per frame for a stride-1 KERNEL_SZ x KERNEL_SZ kernel.
   function automatic int win_count(input int h, input int w);
      return (h - KERNEL_SZ + 1) * (w - KERNEL_SZ + 1);
   endfunction

endpackage : cnn_pkg

// File: rtl/line_buf_row.sv
// ---------------------------------------------------------------------------
// line_buf_row
// One image row of pixel storage (IMG_W entries of PIX_W bits).
// Asynchronous indexed read and synchronous write at the same address, so a
// read in the write cycle returns the old contents (read-before-write).
// Storage is deliberately not reset so it can map onto distributed RAM / SRL.
// Ports:
//   clk   in  : clock
//   we    in  : write enable
//   addr  in  : column index for both read and write
//   wdata in  : pixel to store
//   rdata out : pixel currently stored at addr
// ---------------------------------------------------------------------------
module line_buf_row #(
   parameter int PIX_W = 8,
   parameter int IMG_W = 8
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(IMG_W)-1:0] addr,
   input  logic [PIX_W-1:0]         wdata,
   output logic [PIX_W-1:0]         rdata
);

   logic [PIX_W-1:0] mem_r [IMG_W];

   // Row storage write port.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[addr] <= wdata;
      end
   end

   assign rdata = mem_r[addr];

endmodule : line_buf_row

// File: rtl/act_window_gen.sv
// ---------------------------------------------------------------------------
// act_window_gen
// Turns a raster-order pixel stream into stride-1 3x3 activation windows.
// Two line buffers hold the previous two rows; two-column history registers
// per window row complete the 3x3 neighbourhood with the incoming column.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   frame_rst       : synchronous frame restart (clears row/col position)
//   win_en          : downstream can take windows; gates pixel intake
//   pix_in/pix_vld  : input pixel and its valid
//   pix_rdy         : pixel accepted when pix_vld && pix_rdy
//   activate0/1/2   : window rows r-2, r-1, r; oldest column in MSB byte
//   activate_ready  : one-cycle strobe, new window on activate0..2
//   frame_done      : one-cycle strobe with the last window of the frame
// ---------------------------------------------------------------------------
module act_window_gen
   import cnn_pkg::*;
#(
   parameter int PIX_W = PIX_W_DEF,
   parameter int IMG_W = 8,
   parameter int IMG_H = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         frame_rst,
   input  logic                         win_en,
   input  logic [PIX_W-1:0]             pix_in,
   input  logic                         pix_vld,
   output logic                         pix_rdy,
   output logic [KERNEL_SZ*PIX_W-1:0]   activate0,
   output logic [KERNEL_SZ*PIX_W-1:0]   activate1,
   output logic [KERNEL_SZ*PIX_W-1:0]   activate2,
   output logic                         activate_ready,
   output logic                         frame_done
);

   localparam int WORD_W = KERNEL_SZ * PIX_W;
   localparam int HIST_W = (KERNEL_SZ - 1) * PIX_W;
   localparam int COL_W  = $clog2(IMG_W);
   localparam int RCNT_W = $clog2(IMG_H);

   localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
   localparam logic [RCNT_W-1:0] ROW_LAST  = RCNT_W'(IMG_H - 1);
   localparam logic [COL_W-1:0]  COL_FIRST = COL_W'(KERNEL_SZ - 1);
   localparam logic [RCNT_W-1:0] ROW_FIRST = RCNT_W'(KERNEL_SZ - 1);

   logic [COL_W-1:0]  col_r;
   logic [RCNT_W-1:0] row_r;
   logic [COL_W-1:0]  col_nxt_s;
   logic [RCNT_W-1:0] row_nxt_s;
   logic              accept_s;
   logic              emit_s;
   logic              last_s;

   logic [PIX_W-1:0]  lb0_rd_s;   // row r-1 at this column
   logic [PIX_W-1:0]  lb1_rd_s;   // row r-2 at this column

   logic [HIST_W-1:0] hist0_r;    // previous two columns of row r-2
   logic [HIST_W-1:0] hist1_r;    // previous two columns of row r-1
   logic [HIST_W-1:0] hist2_r;    // previous two columns of row r

   logic [WORD_W-1:0] act0_r;
   logic [WORD_W-1:0] act1_r;
   logic [WORD_W-1:0] act2_r;
   logic              act_ready_r;
   logic              frame_done_r;

   assign pix_rdy  = win_en && !frame_rst;
   assign accept_s = pix_vld && pix_rdy;

   // lb0 holds row r-1; on accept it takes the new pixel and hands its old
   // contents to lb1, which thereby always holds row r-2.
   line_buf_row #(.PIX_W(PIX_W), .IMG_W(IMG_W)) u_lb0 (
      .clk   (clk),
      .we    (accept_s),
      .addr  (col_r),
      .wdata (pix_in),
      .rdata (lb0_rd_s)
   );

   line_buf_row #(.PIX_W(PIX_W), .IMG_W(IMG_W)) u_lb1 (
      .clk   (clk),
      .we    (accept_s),
      .addr  (col_r),
      .wdata (lb0_rd_s),
      .rdata (lb1_rd_s)
   );

   // Next raster position, wrapping column then row then frame.
   always_comb begin
      col_nxt_s = col_r;
      row_nxt_s = row_r;
      if (col_r == COL_LAST) begin
         col_nxt_s = '0;
         if (row_r == ROW_LAST) begin
            row_nxt_s = '0;
         end else begin
            row_nxt_s = row_r + RCNT_W'(1);
         end
      end else begin
         col_nxt_s = col_r + COL_W'(1);
         row_nxt_s = row_r;
      end
   end

   // A window exists only once two full rows and two columns precede it,
   // which also keeps windows from straddling a row boundary.
   always_comb begin
      emit_s = accept_s && (row_r >= ROW_FIRST) && (col_r >= COL_FIRST);
      last_s = accept_s && (row_r == ROW_LAST) && (col_r == COL_LAST);
   end

   // Raster position counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_r <= '0;
         row_r <= '0;
      end else if (frame_rst) begin
         col_r <= '0;
         row_r <= '0;
      end else if (accept_s) begin
         col_r <= col_nxt_s;
         row_r <= row_nxt_s;
      end
   end

   // Column history: shift the newest column in at the LSB end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist0_r <= '0;
         hist1_r <= '0;
         hist2_r <= '0;
      end else if (accept_s) begin
         hist0_r <= {hist0_r[PIX_W-1:0], lb1_rd_s};
         hist1_r <= {hist1_r[PIX_W-1:0], lb0_rd_s};
         hist2_r <= {hist2_r[PIX_W-1:0], pix_in};
      end
   end

   // Registered window outputs and strobes; windows hold between emits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act0_r       <= '0;
         act1_r       <= '0;
         act2_r       <= '0;
         act_ready_r  <= 1'b0;
         frame_done_r <= 1'b0;
      end else if (frame_rst) begin
         act_ready_r  <= 1'b0;
         frame_done_r <= 1'b0;
      end else begin
         act_ready_r  <= emit_s;
         frame_done_r <= last_s;
         if (emit_s) begin
            act0_r <= {hist0_r, lb1_rd_s};
            act1_r <= {hist1_r, lb0_rd_s};
            act2_r <= {hist2_r, pix_in};
         end
      end
   end

   assign activate0      = act0_r;
   assign activate1      = act1_r;
   assign activate2      = act2_r;
   assign activate_ready = act_ready_r;
   assign frame_done     = frame_done_r;

endmodule : act_window_gen
